ex_wb_skid_stage: RTL and testbench

Parametrised EX/WB pipeline stage with valid/ready handshake, 2-entry skid buffer, synchronous flush and write-data select.
- Sits between the EX stage (ALU/immediate path) and WB (register file write port).
- Replaces the unconditional EX/WB register, so WB backpressure can stall EX without losing results.
- Exposes the youngest pending write for EX forwarding.

---
 rtl/ex_wb_skid_stage_pkg.sv | 25 ++
 rtl/ex_wb_skid_stage_if.sv | 43 ++++
 rtl/ex_wb_skid_stage_pipe_slot.sv | 34 +++
 rtl/ex_wb_skid_stage.sv | 106 ++++++++++
 tb/tb_ex_wb_skid_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_wb_skid_stage_pkg.sv
// Shared EX/WB pipeline definitions: default widths, payload layout and write-data select.
package ex_wb_skid_stage_pkg;

  localparam int DW_DEF = 8;
  localparam int RW_DEF = 3;
  localparam int IW_DEF = 8;
  localparam int SEL_W  = 32;

  typedef struct packed {
    logic              regwrite;
    logic              immload;
    logic [DW_DEF-1:0] alures;
    logic [DW_DEF-1:0] immdata;
    logic [RW_DEF-1:0] writereg;
    logic [IW_DEF-1:0] instr;
  } ex_wb_payload_t;

  // Operates at SEL_W so any data width up to 32 can use it via a cast at the call site.
  function automatic logic [SEL_W-1:0] wdata_sel(input logic             immload,
                                                 input logic [SEL_W-1:0] alures,
                                                 input logic [SEL_W-1:0] immdata);
    return immload ? immdata : alures;
  endfunction

endpackage

// File: rtl/ex_wb_skid_stage_if.sv
// EX-side, WB-side and forwarding signals of the EX/WB skid stage.
interface ex_wb_skid_stage_if #(
  parameter int DW = 8,
  parameter int RW = 3,
  parameter int IW = 8
);
  logic          flush;
  logic          ex_valid;
  logic          ex_ready;
  logic          ex_regwrite;
  logic          ex_immload;
  logic [DW-1:0] ex_alures;
  logic [DW-1:0] ex_immdata;
  logic [RW-1:0] ex_writereg;
  logic [IW-1:0] ex_instr;
  logic          wb_valid;
  logic          wb_ready;
  logic          wb_regwrite;
  logic          wb_immload;
  logic [DW-1:0] wb_alures;
  logic [DW-1:0] wb_immdata;
  logic [RW-1:0] wb_writereg;
  logic [IW-1:0] wb_instr;
  logic [DW-1:0] wb_wdata;
  logic          fwd_valid;
  logic [RW-1:0] fwd_reg;
  logic [DW-1:0] fwd_data;
  logic [1:0]    occupancy;

  modport master (
    output flush, ex_valid, ex_regwrite, ex_immload, ex_alures, ex_immdata,
           ex_writereg, ex_instr, wb_ready,
    input  ex_ready, wb_valid, wb_regwrite, wb_immload, wb_alures, wb_immdata,
           wb_writereg, wb_instr, wb_wdata, fwd_valid, fwd_reg, fwd_data, occupancy
  );

  modport slave (
    input  flush, ex_valid, ex_regwrite, ex_immload, ex_alures, ex_immdata,
           ex_writereg, ex_instr, wb_ready,
    output ex_ready, wb_valid, wb_regwrite, wb_immload, wb_alures, wb_immdata,
           wb_writereg, wb_instr, wb_wdata, fwd_valid, fwd_reg, fwd_data, occupancy
  );
endinterface

// File: rtl/ex_wb_skid_stage_pipe_slot.sv
// One valid bit plus payload register; clear wins over load.
module pipe_slot
  import ex_wb_skid_stage_pkg::*;
#(
  parameter type T = ex_wb_payload_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_clr,
  input  T     i_d,
  output logic o_valid,
  output T     o_q
);

  logic r_valid;
  T     r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;

endmodule

// File: rtl/ex_wb_skid_stage.sv
// EX/WB stage with a 2-entry skid buffer: head drives WB, skid absorbs one entry under backpressure.
module ex_wb_skid_stage
  import ex_wb_skid_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  ex_wb_skid_stage_if.slave  bus
);

  typedef struct packed {
    logic          regwrite;
    logic          immload;
    logic [DW-1:0] alures;
    logic [DW-1:0] immdata;
    logic [RW-1:0] writereg;
    logic [IW-1:0] instr;
    logic [DW-1:0] wdata;
  } payload_t;

  payload_t w_in, w_head_d, w_head_q, w_skid_q, w_src;
  logic     w_head_v, w_skid_v, w_push, w_pop;
  logic     w_head_load, w_head_clr, w_skid_load, w_skid_clr;

  always_comb begin
    w_in          = '0;
    w_in.regwrite = bus.ex_regwrite;
    w_in.immload  = bus.ex_immload;
    w_in.alures   = bus.ex_alures;
    w_in.immdata  = bus.ex_immdata;
    w_in.writereg = bus.ex_writereg;
    w_in.instr    = bus.ex_instr;
    w_in.wdata    = DW'(wdata_sel(bus.ex_immload, SEL_W'(bus.ex_alures), SEL_W'(bus.ex_immdata)));
  end

  // ex_ready comes straight from the skid valid flop, keeping wb_ready off the EX timing path.
  assign w_push = bus.ex_valid & ~w_skid_v;
  assign w_pop  = w_head_v & bus.wb_ready;

  always_comb begin
    w_head_load = 1'b0;
    w_head_clr  = 1'b0;
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
    w_head_d    = w_in;
    if (bus.flush) begin
      w_head_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else if (w_skid_v) begin
      if (w_pop) begin
        w_head_load = 1'b1;
        w_head_d    = w_skid_q;
        w_skid_clr  = 1'b1;
      end
    end else if (!w_head_v) begin
      w_head_load = w_push;
    end else if (w_push && w_pop) begin
      w_head_load = 1'b1;
    end else if (w_push) begin
      w_skid_load = 1'b1;
    end else if (w_pop) begin
      w_head_clr = 1'b1;
    end
  end

  pipe_slot #(.T(payload_t)) u_head (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_head_load),
    .i_clr   (w_head_clr),
    .i_d     (w_head_d),
    .o_valid (w_head_v),
    .o_q     (w_head_q)
  );

  pipe_slot #(.T(payload_t)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clr   (w_skid_clr),
    .i_d     (w_in),
    .o_valid (w_skid_v),
    .o_q     (w_skid_q)
  );

  assign bus.ex_ready    = ~w_skid_v;
  assign bus.wb_valid    = w_head_v;
  assign bus.wb_regwrite = w_head_v & w_head_q.regwrite;
  assign bus.wb_immload  = w_head_q.immload;
  assign bus.wb_alures   = w_head_q.alures;
  assign bus.wb_immdata  = w_head_q.immdata;
  assign bus.wb_writereg = w_head_q.writereg;
  assign bus.wb_instr    = w_head_q.instr;
  assign bus.wb_wdata    = w_head_q.wdata;

  // Youngest entry wins, even when it does not write the register file.
  assign w_src         = w_skid_v ? w_skid_q : w_head_q;
  assign bus.fwd_valid = (w_skid_v | w_head_v) & w_src.regwrite;
  assign bus.fwd_reg   = w_src.writereg;
  assign bus.fwd_data  = w_src.wdata;
  assign bus.occupancy = {1'b0, w_head_v} + {1'b0, w_skid_v};

endmodule

// File: tb/tb_ex_wb_skid_stage.sv
// Bench for ex_wb_skid_stage: 8-bit and 16-bit instances share stimulus and a depth-2 FIFO model.
module tb_ex_wb_skid_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s_valid = 0, s_rw = 0, s_il = 0, s_flush = 0, s_wbr = 0;
  logic [15:0] s_alu = 0, s_imm = 0, s_ins = 0;
  logic [4:0]  s_reg = 0;

  ex_wb_skid_stage_if #(.DW(8),  .RW(3), .IW(8))  bus8 ();
  ex_wb_skid_stage_if #(.DW(16), .RW(5), .IW(16)) bus16 ();

  assign bus8.flush        = s_flush;
  assign bus8.ex_valid     = s_valid;
  assign bus8.ex_regwrite  = s_rw;
  assign bus8.ex_immload   = s_il;
  assign bus8.ex_alures    = s_alu[7:0];
  assign bus8.ex_immdata   = s_imm[7:0];
  assign bus8.ex_writereg  = s_reg[2:0];
  assign bus8.ex_instr     = s_ins[7:0];
  assign bus8.wb_ready     = s_wbr;
  assign bus16.flush       = s_flush;
  assign bus16.ex_valid    = s_valid;
  assign bus16.ex_regwrite = s_rw;
  assign bus16.ex_immload  = s_il;
  assign bus16.ex_alures   = s_alu;
  assign bus16.ex_immdata  = s_imm;
  assign bus16.ex_writereg = s_reg;
  assign bus16.ex_instr    = s_ins;
  assign bus16.wb_ready    = s_wbr;

  ex_wb_skid_stage #(.DW(8),  .RW(3), .IW(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  ex_wb_skid_stage #(.DW(16), .RW(5), .IW(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Reference: a FIFO of at most two entries; ready means not full.
  typedef struct {
    logic        rw, il;
    logic [15:0] alu, imm, ins;
    logic [4:0]  rg;
  } ent_t;
  ent_t q[$];
  ent_t m_new;
  bit   m_push, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else begin
      m_push = s_valid && (q.size() < 2);
      m_pop  = (q.size() > 0) && s_wbr;
      m_new  = '{rw: s_rw, il: s_il, alu: s_alu, imm: s_imm, ins: s_ins, rg: s_reg};
      if (s_flush) q.delete();
      else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(m_new);
      end
    end
  end

  int          c_n;
  ent_t        c_h, c_y;
  logic [15:0] c_wd, c_fd;
  logic        c_fv;

  always @(negedge clk) begin
    c_n = q.size();
    chk("occ8",  32'(bus8.occupancy),  32'(c_n));
    chk("occ16", 32'(bus16.occupancy), 32'(c_n));
    chk("rdy8",  32'(bus8.ex_ready),   32'(c_n < 2));
    chk("rdy16", 32'(bus16.ex_ready),  32'(c_n < 2));
    chk("wbv8",  32'(bus8.wb_valid),   32'(c_n > 0));
    chk("wbv16", 32'(bus16.wb_valid),  32'(c_n > 0));
    if (c_n > 0) begin
      c_h  = q[0];
      c_wd = c_h.il ? c_h.imm : c_h.alu;
      chk("wdata8",  32'(bus8.wb_wdata),     32'(c_wd[7:0]));
      chk("wdata16", 32'(bus16.wb_wdata),    32'(c_wd));
      chk("alu16",   32'(bus16.wb_alures),   32'(c_h.alu));
      chk("imm16",   32'(bus16.wb_immdata),  32'(c_h.imm));
      chk("ins16",   32'(bus16.wb_instr),    32'(c_h.ins));
      chk("reg8",    32'(bus8.wb_writereg),  32'(c_h.rg[2:0]));
      chk("reg16",   32'(bus16.wb_writereg), 32'(c_h.rg));
      chk("il8",     32'(bus8.wb_immload),   32'(c_h.il));
      chk("rw8",     32'(bus8.wb_regwrite),  32'(c_h.rw));
      chk("rw16",    32'(bus16.wb_regwrite), 32'(c_h.rw));
      c_y = q[c_n-1];
    end else begin
      chk("rw8_idle",  32'(bus8.wb_regwrite),  32'(0));
      chk("rw16_idle", 32'(bus16.wb_regwrite), 32'(0));
    end
    c_fv = (c_n > 0) && c_y.rw;
    chk("fwdv8",  32'(bus8.fwd_valid),  32'(c_fv));
    chk("fwdv16", 32'(bus16.fwd_valid), 32'(c_fv));
    if (c_fv) begin
      c_fd = c_y.il ? c_y.imm : c_y.alu;
      chk("fwdreg16",  32'(bus16.fwd_reg),  32'(c_y.rg));
      chk("fwddata8",  32'(bus8.fwd_data),  32'(c_fd[7:0]));
      chk("fwddata16", 32'(bus16.fwd_data), 32'(c_fd));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, rw, il, input logic [15:0] alu, imm,
                     input logic [4:0] rg, input logic [15:0] ins);
    s_valid = v; s_rw = rw; s_il = il; s_alu = alu; s_imm = imm; s_reg = rg; s_ins = ins;
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    step();

    // Reset in the middle of a transfer
    drv(1, 1, 0, 16'h1299, 16'h0, 5'd5, 16'h0101);
    step();
    chk("pre_rst_occ", 32'(bus8.occupancy), 32'd1);
    chk("pre_rst_alu", 32'(bus8.wb_alures), 32'h99);
    drv(1, 1, 0, 16'h003C, 16'h0, 5'd2, 16'h0202);
    #1 rst = 1'b1;
    #1;
    chk("rst_wbv",   32'(bus8.wb_valid),    32'd0);
    chk("rst_occ",   32'(bus8.occupancy),   32'd0);
    chk("rst_rdy",   32'(bus8.ex_ready),    32'd1);
    chk("rst_alu",   32'(bus8.wb_alures),   32'd0);
    chk("rst_wdata", 32'(bus8.wb_wdata),    32'd0);
    chk("rst_reg",   32'(bus16.wb_writereg), 32'd0);
    chk("rst_fwdv",  32'(bus8.fwd_valid),   32'd0);
    step();
    chk("rst_nocap", 32'(bus8.occupancy), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_wbv",   32'(bus8.wb_valid), 32'd1);
    chk("post_rst_wdata", 32'(bus8.wb_wdata), 32'h3C);
    s_valid = 0; s_wbr = 1;
    step();

    // Streaming at full rate
    for (int i = 1; i <= 5; i++) begin
      drv(1, 1, 0, 16'hA000 | 16'(i), 16'h0, 5'd2, 16'(i));
      step();
      chk("stream_wdata", 32'(bus8.wb_wdata), 32'(i));
      chk("stream_occ",   32'(bus8.occupancy <= 2'd1), 32'd1);
    end
    s_valid = 0;
    step();

    // Full-width payload on the wide instance
    s_wbr = 0;
    drv(1, 1, 0, 16'hBEEF, 16'h1234, 5'd31, 16'hC0DE);
    step();
    chk("beef16",  32'(bus16.wb_wdata),    32'hBEEF);
    chk("reg31",   32'(bus16.wb_writereg), 32'd31);
    chk("beef8",   32'(bus8.wb_wdata),     32'hEF);
    chk("reg7",    32'(bus8.wb_writereg),  32'd7);
    chk("fwd31",   32'(bus16.fwd_reg),     32'd31);
    s_valid = 0; s_wbr = 1;
    step();

    // Backpressure: A, B fill the stage, C waits
    s_wbr = 0;
    drv(1, 1, 0, 16'hBE11, 16'h0, 5'd1, 16'h00A1);
    step();
    drv(1, 1, 1, 16'h0099, 16'hBE22, 5'd6, 16'h00B2);
    step();
    chk("bp_occ",   32'(bus8.occupancy), 32'd2);
    chk("bp_rdy",   32'(bus8.ex_ready),  32'd0);
    chk("bp_fwdr",  32'(bus8.fwd_reg),   32'd6);
    chk("bp_fwdd",  32'(bus8.fwd_data),  32'h22);
    chk("bp_fwd16", 32'(bus16.fwd_data), 32'hBE22);
    drv(1, 1, 0, 16'h0033, 16'h0, 5'd4, 16'h00C3);
    step(); step();
    chk("bp_hold_occ", 32'(bus8.occupancy), 32'd2);
    chk("bp_head_a",   32'(bus8.wb_wdata),  32'h11);
    s_wbr = 1;
    step();
    chk("bp_head_b", 32'(bus8.wb_wdata), 32'h22);
    step();
    chk("bp_head_c", 32'(bus8.wb_wdata), 32'h33);
    s_valid = 0;
    step();
    chk("bp_drain", 32'(bus8.occupancy), 32'd0);

    // Flush with a concurrent push, from full and from one entry
    s_wbr = 0;
    drv(1, 1, 0, 16'h0041, 16'h0, 5'd3, 16'h0);
    step(); step();
    s_flush = 1;
    step();
    chk("fl_occ",  32'(bus8.occupancy),   32'd0);
    chk("fl_wbv",  32'(bus8.wb_valid),    32'd0);
    chk("fl_rw",   32'(bus8.wb_regwrite), 32'd0);
    chk("fl_rdy",  32'(bus8.ex_ready),    32'd1);
    chk("fl_fwdv", 32'(bus8.fwd_valid),   32'd0);
    s_flush = 0;
    step();
    s_flush = 1;
    step();
    chk("fl1_occ", 32'(bus8.occupancy), 32'd0);
    s_flush = 0; s_valid = 0;
    step();

    // Write-data select and regwrite gating
    drv(1, 1, 1, 16'h00AA, 16'h0055, 5'd2, 16'h0);
    step();
    chk("mux_wdata", 32'(bus8.wb_wdata), 32'h55);
    chk("mux_fwdd",  32'(bus8.fwd_data), 32'h55);
    drv(1, 0, 0, 16'h0077, 16'h0, 5'd5, 16'h0);
    step();
    chk("young_nw_fwdv", 32'(bus8.fwd_valid),   32'd0);
    chk("young_nw_rw",   32'(bus8.wb_regwrite), 32'd1);
    s_valid = 0; s_wbr = 1;
    step();
    chk("nw_wbv",  32'(bus8.wb_valid),    32'd1);
    chk("nw_rw",   32'(bus8.wb_regwrite), 32'd0);
    chk("nw_fwdv", 32'(bus8.fwd_valid),   32'd0);
    step();

    // Randomised traffic; EX holds its entry while not ready
    for (int i = 0; i < 3000; i++) begin
      s_wbr   = ($urandom_range(0, 3) != 0) ^ (i % 400 < 100);
      s_flush = ($urandom_range(0, 47) == 0);
      if (!(s_valid && !bus8.ex_ready)) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_rw    = $urandom_range(0, 1);
        s_il    = $urandom_range(0, 1);
        s_alu   = 16'($urandom);
        s_imm   = 16'($urandom);
        s_reg   = 5'($urandom);
        s_ins   = 16'($urandom);
      end
      step();
    end
    s_valid = 0; s_flush = 0;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
